// File: rtl/cdb_wb_arbiter_pkg.sv
// Shared defaults and the common-data-bus record for the Tomasulo writeback path.
package tomasulo_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int TAG_W_DEF   = 4;
  localparam int NUM_REQ_DEF = 4;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]  data;
  } cdb_t;

  // Pointer width that still works for a single requester.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_wb_arbiter_if.sv
// Writeback bus between functional units, the arbiter, the register file and the CDB.
// Handshake: a requester holds req_valid and its payload stable until it sees
// req_ready high at a posedge; valid&ready at that posedge is one transfer.
interface cdb_wb_arbiter_if
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int TAG_W   = TAG_W_DEF
);
  logic                           flush;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][4:0]        req_rd;
  logic [NUM_REQ-1:0][TAG_W-1:0]  req_tag;
  logic [NUM_REQ-1:0][XLEN-1:0]   req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           rf_we;
  logic [4:0]                     rf_waddr;
  logic [XLEN-1:0]                rf_wdata;
  logic                           cdb_valid;
  logic [TAG_W-1:0]               cdb_tag;
  logic [XLEN-1:0]                cdb_data;

  modport slave (
    input  flush, req_valid, req_rd, req_tag, req_data,
    output req_ready, rf_we, rf_waddr, rf_wdata, cdb_valid, cdb_tag, cdb_data
  );

  modport master (
    output flush, req_valid, req_rd, req_tag, req_data,
    input  req_ready, rf_we, rf_waddr, rf_wdata, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_wb_arbiter_rr.sv
// Purely combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);

  always_comb begin
    grant_o   = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any_o && req_i[(int'(ptr_i) + k) % N]) begin
        gnt_any_o                          = 1'b1;
        gnt_idx_o                          = PTR_W'((int'(ptr_i) + k) % N);
        grant_o[(int'(ptr_i) + k) % N]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Writeback arbiter: one functional-unit result per cycle onto the CDB and the
// register-file write port, with round-robin fairness and a squashing flush.
module cdb_wb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int XLEN    = XLEN_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  cdb_wb_arbiter_if.slave             wb,
  output logic [ptr_w(NUM_REQ)-1:0]   rr_ptr_o
);

  localparam int PTR_W = ptr_w(NUM_REQ);

  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q,   cdb_tag_d;
  logic [XLEN-1:0]    cdb_data_q,  cdb_data_d;
  logic               rf_we_q,     rf_we_d;
  logic [4:0]         rf_waddr_q,  rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q,  rf_wdata_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               fire;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req_i     (wb.req_valid),
    .ptr_i     (rr_ptr_q),
    .grant_o   (grant),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Ready is gated by reset and flush so no handshake can complete while squashing.
  assign wb.req_ready = (rst_n && !wb.flush) ? grant : '0;
  assign fire         = gnt_any && !wb.flush;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    if (wb.flush) begin
      rr_ptr_d = '0;
    end else if (fire) begin
      rr_ptr_d    = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      cdb_valid_d = 1'b1;
      cdb_tag_d   = wb.req_tag[gnt_idx];
      cdb_data_d  = wb.req_data[gnt_idx];
      // x0 results still broadcast so waiting stations wake, but never write.
      if (wb.req_rd[gnt_idx] != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = wb.req_rd[gnt_idx];
        rf_wdata_d = wb.req_data[gnt_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  assign wb.cdb_valid = cdb_valid_q;
  assign wb.cdb_tag   = cdb_tag_q;
  assign wb.cdb_data  = cdb_data_q;
  assign wb.rf_we     = rf_we_q;
  assign wb.rf_waddr  = rf_waddr_q;
  assign wb.rf_wdata  = rf_wdata_q;
  assign rr_ptr_o     = rr_ptr_q;

endmodule
